// File: rtl/ga_pkg.sv
// Shared GA definitions: arbiter FSM encoding, default widths and a timer sizing helper.
package ga_pkg;

  localparam int unsigned DefErrorWidth      = 32;
  localparam int unsigned DefIndividualWidth = 32;
  localparam int unsigned DefRequesters      = 4;
  localparam int unsigned DefTimeoutCycles   = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } arbState_t;

  // Bits needed to count 0..cycles; a disabled timeout still keeps a 1-bit timer.
  function automatic int unsigned timerWidth(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first set request after lastGrant, wrapping.
module round_robin_picker
  import ga_pkg::*;
#(
  parameter int unsigned Requesters = DefRequesters
) (
  input  logic [Requesters-1:0]         request,
  input  logic [$clog2(Requesters)-1:0] lastGrant,
  output logic [Requesters-1:0]         grant,
  output logic                          valid
);

  localparam int unsigned PtrWidth = $clog2(Requesters);

  logic [PtrWidth-1:0] idx;

  // Scan lastGrant+1 .. lastGrant+Requesters; the last grant itself is checked last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned offset = 1; offset <= Requesters; offset++) begin
      idx = PtrWidth'((32'(lastGrant) + offset) % Requesters);
      if (!valid && request[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fitness_arbiter.sv
// Arbitrates several GA requesters onto one shared fitness unit, with optional timeout.
module fitness_arbiter
  import ga_pkg::*;
#(
  parameter int unsigned ErrorWidth      = DefErrorWidth,
  parameter int unsigned IndividualWidth = DefIndividualWidth,
  parameter int unsigned Requesters      = DefRequesters,
  parameter int unsigned TimeoutCycles   = DefTimeoutCycles
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [Requesters-1:0]                 reqStart,
  input  logic [Requesters*IndividualWidth-1:0] reqIndividual,
  output logic [Requesters-1:0]                 reqFinish,
  output logic [ErrorWidth-1:0]                 reqError,
  output logic                                  reqTimeout,
  output logic [Requesters-1:0]                 grant,
  output logic                                  busy,
  output logic                                  fitStart,
  output logic [IndividualWidth-1:0]            fitIndividual,
  input  logic                                  fitFinish,
  input  logic [ErrorWidth-1:0]                 fitError,
  output logic                                  fitAbort
);

  localparam int unsigned PtrWidth   = $clog2(Requesters);
  localparam int unsigned TimerWidth = timerWidth(TimeoutCycles);
  localparam bit          TimeoutEn  = (TimeoutCycles != 0);
  localparam logic [TimerWidth-1:0] TimerLast =
      TimeoutEn ? TimerWidth'(TimeoutCycles - 1) : '0;
  localparam logic [TimerWidth-1:0] TimerMax  = '1;
  localparam logic [PtrWidth-1:0]   PtrReset  = PtrWidth'(Requesters - 1);

  arbState_t                  stateQ, stateD;
  logic [Requesters-1:0]      grantQ, grantD;
  logic [PtrWidth-1:0]        lastGrantQ, lastGrantD;
  logic [TimerWidth-1:0]      timerQ, timerD;
  logic [IndividualWidth-1:0] indivQ, indivD;
  logic [ErrorWidth-1:0]      errorQ, errorD;
  logic                       timeoutQ, timeoutD;

  logic [Requesters-1:0]      pickGrant;
  logic                       pickValid;
  logic [IndividualWidth-1:0] pickIndividual;
  logic [PtrWidth-1:0]        grantIdx;
  logic                       timeoutHit;
  logic                       respond;

  round_robin_picker #(
    .Requesters(Requesters)
  ) uPicker (
    .request  (reqStart),
    .lastGrant(lastGrantQ),
    .grant    (pickGrant),
    .valid    (pickValid)
  );

  // AND-OR mux of the picked requester's individual.
  always_comb begin
    pickIndividual = '0;
    for (int unsigned i = 0; i < Requesters; i++) begin
      if (pickGrant[i]) begin
        pickIndividual = pickIndividual | reqIndividual[i*IndividualWidth +: IndividualWidth];
      end
    end
  end

  // One-hot grant back to an index for the round-robin pointer.
  always_comb begin
    grantIdx = '0;
    for (int unsigned i = 0; i < Requesters; i++) begin
      if (grantQ[i]) begin
        grantIdx = PtrWidth'(i);
      end
    end
  end

  assign timeoutHit = TimeoutEn && (timerQ == TimerLast);

  // Next-state logic; fitFinish wins over a coincident timeout.
  always_comb begin
    stateD     = stateQ;
    grantD     = grantQ;
    lastGrantD = lastGrantQ;
    timerD     = timerQ;
    indivD     = indivQ;
    errorD     = errorQ;
    timeoutD   = timeoutQ;
    unique case (stateQ)
      StIdle: begin
        if (pickValid) begin
          grantD = pickGrant;
          indivD = pickIndividual;
          stateD = StIssue;
        end
      end
      StIssue: begin
        timerD = '0;
        stateD = StWait;
      end
      StWait: begin
        if (fitFinish) begin
          errorD   = fitError;
          timeoutD = 1'b0;
          stateD   = StRespond;
        end else if (timeoutHit) begin
          errorD   = '1;
          timeoutD = 1'b1;
          stateD   = StRespond;
        end else if (timerQ != TimerMax) begin
          timerD = timerQ + 1'b1;
        end
      end
      StRespond: begin
        lastGrantD = grantIdx;
        grantD     = '0;
        stateD     = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // State registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= StIdle;
      grantQ     <= '0;
      lastGrantQ <= PtrReset;
      timerQ     <= '0;
      indivQ     <= '0;
      errorQ     <= '0;
      timeoutQ   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      grantQ     <= grantD;
      lastGrantQ <= lastGrantD;
      timerQ     <= timerD;
      indivQ     <= indivD;
      errorQ     <= errorD;
      timeoutQ   <= timeoutD;
    end
  end

  assign respond       = (stateQ == StRespond);
  assign grant         = grantQ;
  assign busy          = (stateQ != StIdle);
  assign fitStart      = (stateQ == StIssue);
  assign fitIndividual = indivQ;
  assign reqFinish     = respond ? grantQ : '0;
  assign reqError      = respond ? errorQ : '0;
  assign reqTimeout    = respond & timeoutQ;
  assign fitAbort      = respond & timeoutQ;

endmodule

// File: tb/tb_fitness_arbiter.sv
// Directed bench for fitness_arbiter (4 requesters, 8-cycle timeout).
module tb_fitness_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   reqStart;
  logic [127:0] reqIndividual;
  logic [3:0]   reqFinish;
  logic [31:0]  reqError;
  logic         reqTimeout;
  logic [3:0]   grant;
  logic         busy;
  logic         fitStart;
  logic [31:0]  fitIndividual;
  logic         fitFinish;
  logic [31:0]  fitError;
  logic         fitAbort;

  int checkCount = 0;
  int passCount  = 0;

  logic [3:0]  fairGrant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] fairIndiv [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};

  fitness_arbiter #(
    .ErrorWidth     (32),
    .IndividualWidth(32),
    .Requesters     (4),
    .TimeoutCycles  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reqStart     (reqStart),
    .reqIndividual(reqIndividual),
    .reqFinish    (reqFinish),
    .reqError     (reqError),
    .reqTimeout   (reqTimeout),
    .grant        (grant),
    .busy         (busy),
    .fitStart     (fitStart),
    .fitIndividual(fitIndividual),
    .fitFinish    (fitFinish),
    .fitError     (fitError),
    .fitAbort     (fitAbort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drive fitFinish for one cycle after `delay` further cycles; returns in the next cycle.
  task automatic finishAfter(input int delay, input logic [31:0] err);
    repeat (delay) tick();
    fitFinish = 1'b1;
    fitError  = err;
    tick();
    fitFinish = 1'b0;
    fitError  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    reqStart      = 4'b0000;
    reqIndividual = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    fitFinish     = 1'b0;
    fitError      = '0;
    tick();
    tick();

    // Reset values.
    check("rst grant", 32'(grant), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst reqFinish", 32'(reqFinish), 32'h0);
    check("rst reqError", reqError, 32'h0);
    check("rst reqTimeout", 32'(reqTimeout), 32'h0);
    check("rst fitStart", 32'(fitStart), 32'h0);
    check("rst fitAbort", 32'(fitAbort), 32'h0);
    check("rst fitIndividual", fitIndividual, 32'h0);
    rst = 1'b1;
    tick();
    check("idle busy", 32'(busy), 32'h0);

    // Single request, fitness unit answers 5 cycles after fitStart.
    reqIndividual[31:0] = 32'h12345678;
    reqStart = 4'b0001;
    tick();
    check("single fitStart", 32'(fitStart), 32'h1);
    check("single grant", 32'(grant), 32'h1);
    check("single fitIndividual", fitIndividual, 32'h12345678);
    check("single busy", 32'(busy), 32'h1);
    tick();
    check("single fitStart pulse", 32'(fitStart), 32'h0);
    finishAfter(4, 32'h00000042);
    check("single reqFinish", 32'(reqFinish), 32'h1);
    check("single reqError", reqError, 32'h42);
    check("single reqTimeout", 32'(reqTimeout), 32'h0);
    check("single fitAbort", 32'(fitAbort), 32'h0);
    check("single fitIndividual hold", fitIndividual, 32'h12345678);
    reqStart = 4'b0000;
    tick();
    check("single idle reqFinish", 32'(reqFinish), 32'h0);
    check("single idle busy", 32'(busy), 32'h0);
    check("single idle grant", 32'(grant), 32'h0);

    // Fairness from a fresh reset with all four requesting continuously.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    reqIndividual = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    reqStart = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fair%0d fitStart", k), 32'(fitStart), 32'h1);
      check($sformatf("fair%0d grant", k), 32'(grant), 32'(fairGrant[k]));
      check($sformatf("fair%0d fitIndividual", k), fitIndividual, fairIndiv[k]);
      finishAfter(1, 32'h100 + 32'(k));
      check($sformatf("fair%0d reqFinish", k), 32'(reqFinish), 32'(fairGrant[k]));
      check($sformatf("fair%0d reqError", k), reqError, 32'h100 + 32'(k));
      if (k == 4) reqStart = 4'b0000;
      tick();
      check($sformatf("fair%0d idle gap", k), 32'(busy), 32'h0);
      tick();
    end

    // Timeout: no fitFinish; lastGrant is 0, so requester 1 is served.
    reqStart = 4'b0010;
    tick();
    check("tmo fitStart", 32'(fitStart), 32'h1);
    check("tmo grant", 32'(grant), 32'h2);
    repeat (8) tick();
    check("tmo last wait reqFinish", 32'(reqFinish), 32'h0);
    check("tmo last wait fitAbort", 32'(fitAbort), 32'h0);
    check("tmo last wait busy", 32'(busy), 32'h1);
    tick();
    check("tmo reqFinish", 32'(reqFinish), 32'h2);
    check("tmo fitAbort", 32'(fitAbort), 32'h1);
    check("tmo reqError", reqError, 32'hFFFFFFFF);
    check("tmo reqTimeout", 32'(reqTimeout), 32'h1);
    reqStart = 4'b0000;
    tick();
    check("tmo fitAbort pulse", 32'(fitAbort), 32'h0);
    check("tmo idle busy", 32'(busy), 32'h0);

    // Race: fitFinish in the final timeout cycle; lastGrant is 1, so 3 beats 0.
    reqStart = 4'b1001;
    tick();
    check("race grant", 32'(grant), 32'h8);
    check("race fitIndividual", fitIndividual, 32'hA3);
    repeat (8) tick();
    fitFinish = 1'b1;
    fitError  = 32'hABCD0001;
    tick();
    fitFinish = 1'b0;
    fitError  = '0;
    check("race reqFinish", 32'(reqFinish), 32'h8);
    check("race reqTimeout", 32'(reqTimeout), 32'h0);
    check("race reqError", reqError, 32'hABCD0001);
    check("race fitAbort", 32'(fitAbort), 32'h0);
    reqStart = 4'b0000;
    tick();
    check("race idle busy", 32'(busy), 32'h0);

    // Spurious fitFinish while idle.
    fitFinish = 1'b1;
    fitError  = 32'hDEAD;
    tick();
    fitFinish = 1'b0;
    fitError  = '0;
    check("spur busy", 32'(busy), 32'h0);
    check("spur fitStart", 32'(fitStart), 32'h0);
    check("spur reqFinish", 32'(reqFinish), 32'h0);
    check("spur grant", 32'(grant), 32'h0);
    tick();
    check("spur busy later", 32'(busy), 32'h0);

    // Requester 2 drops its request mid-WAIT; it still gets its finish pulse.
    reqStart = 4'b0100;
    tick();
    check("drop grant", 32'(grant), 32'h4);
    tick();
    tick();
    reqStart = 4'b0000;
    tick();
    tick();
    check("drop busy", 32'(busy), 32'h1);
    check("drop grant held", 32'(grant), 32'h4);
    fitFinish = 1'b1;
    fitError  = 32'h55;
    tick();
    fitFinish = 1'b0;
    fitError  = '0;
    check("drop reqFinish", 32'(reqFinish), 32'h4);
    check("drop reqError", reqError, 32'h55);
    tick();
    check("drop reqFinish once", 32'(reqFinish), 32'h0);
    check("drop idle busy", 32'(busy), 32'h0);
    tick();
    check("drop no regrant", 32'(busy), 32'h0);

    // Reset mid-WAIT, then a stray fitFinish.
    reqStart = 4'b0001;
    tick();
    check("rstwait grant", 32'(grant), 32'h1);
    tick();
    tick();
    tick();
    rst      = 1'b0;
    reqStart = 4'b0000;
    #1;
    check("rstwait async busy", 32'(busy), 32'h0);
    check("rstwait async grant", 32'(grant), 32'h0);
    tick();
    check("rstwait reqFinish", 32'(reqFinish), 32'h0);
    check("rstwait fitAbort", 32'(fitAbort), 32'h0);
    check("rstwait fitIndividual", fitIndividual, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    fitFinish = 1'b1;
    fitError  = 32'h77;
    tick();
    fitFinish = 1'b0;
    fitError  = '0;
    check("stray reqFinish", 32'(reqFinish), 32'h0);
    check("stray busy", 32'(busy), 32'h0);
    check("stray grant", 32'(grant), 32'h0);
    tick();
    check("stray reqFinish later", 32'(reqFinish), 32'h0);
    check("stray fitAbort later", 32'(fitAbort), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fitness_arbiter.md
FITNESS_ARBITER -- requirements
Module: fitness_arbiter

Interface
REQ-001 Parameter ErrorWidth, default 32, width of fitness error values.
REQ-002 Parameter IndividualWidth, default 32, width of one individual.
REQ-003 Parameter Requesters, default 4, number of GA requesters (range 2..16).
REQ-004 Parameter TimeoutCycles, default 1024, maximum WAIT cycles per evaluation; 0 disables the timeout.
REQ-005 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port reqStart, input, Requesters, level request per requester, held until its reqFinish pulse.
REQ-008 Port reqIndividual, input, Requesters*IndividualWidth, requester i at bits [i*IndividualWidth +: IndividualWidth].
REQ-009 Port reqFinish, output, Requesters, one-cycle completion pulse to the served requester.
REQ-010 Port reqError, output, ErrorWidth, result, valid only while any reqFinish bit is 1.
REQ-011 Port reqTimeout, output, 1, high with reqFinish when the result came from a timeout.
REQ-012 Port grant, output, Requesters, one-hot index of the requester being served; all-zero in IDLE.
REQ-013 Port busy, output, 1, high in every state except IDLE.
REQ-014 Port fitStart, output, 1, one-cycle start pulse to the shared fitness unit.
REQ-015 Port fitIndividual, output, IndividualWidth, individual under test, stable from fitStart until the transaction ends.
REQ-016 Port fitFinish, input, 1, one-cycle completion pulse from the fitness unit.
REQ-017 Port fitError, input, ErrorWidth, fitness unit result, sampled when fitFinish is 1.
REQ-018 Port fitAbort, output, 1, one-cycle pulse ordering the fitness unit back to idle after a timeout.

Function
REQ-019 The block SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESPOND.
REQ-020 In IDLE with any reqStart bit set, the block SHALL select the first set bit searching round-robin from lastGrant+1 (wrapping modulo Requesters), register grant and fitIndividual, and enter ISSUE.
REQ-021 In ISSUE, fitStart SHALL be 1 for exactly one cycle; the timer SHALL clear and the FSM SHALL enter WAIT.
REQ-022 In WAIT, fitFinish=1 SHALL latch fitError into reqError, clear reqTimeout, and enter RESPOND.
REQ-023 In WAIT with TimeoutCycles!=0 and timer==TimeoutCycles-1 and fitFinish=0, the block SHALL set reqError to all-ones, set reqTimeout, pulse fitAbort, and enter RESPOND.
REQ-024 fitFinish and the timeout in the same cycle SHALL resolve in favour of fitFinish.
REQ-025 In RESPOND, reqFinish SHALL equal grant for one cycle; lastGrant SHALL take the current grant, and the FSM SHALL return to IDLE.
REQ-026 Latency SHALL be: reqStart seen in IDLE at edge N gives fitStart at cycle N+1, and fitFinish at edge M gives reqFinish at cycle M+1.
REQ-027 fitFinish outside WAIT SHALL be ignored.
REQ-028 Deassertion of a served requester's reqStart mid-transaction SHALL NOT abort the transaction; reqFinish SHALL still pulse.
REQ-029 The timer SHALL be ceil(log2(TimeoutCycles+1)) bits wide and saturate; it SHALL never wrap inside WAIT.
REQ-030 A single requester SHALL be served back-to-back with one IDLE cycle between transactions; no requester SHALL wait more than Requesters-1 other transactions.

Reset
REQ-031 While rst=0, the block SHALL be in IDLE with grant=0, lastGrant=Requesters-1, timer=0, and fitIndividual=0.
REQ-032 While rst=0, reqFinish, reqError, reqTimeout, busy, fitStart and fitAbort SHALL all be 0.
REQ-033 Reset asserted mid-transaction SHALL drop the transaction with no reqFinish and no fitAbort; a fitFinish arriving later SHALL be ignored.

Structure
REQ-034 The FSM state encoding and the default width constants SHALL reside in the shared GA package ga_pkg.
REQ-035 Round-robin selection SHALL be one combinational sub-module round_robin_picker (inputs: request vector, last-grant pointer; output: one-hot grant plus valid).

Verification
REQ-036 Single request: reqStart=0001 with individual 0x12345678, fitness unit finishes 5 cycles after fitStart with 0x00000042 -> fitIndividual=0x12345678, reqFinish=0001, reqError=0x42, reqTimeout=0.
REQ-037 Fairness: reqStart=1111 held with immediate re-request -> grant order 0001,0010,0100,1000,0001.
REQ-038 Timeout: TimeoutCycles=8 and fitFinish never asserted -> fitAbort and reqFinish occur 8 cycles after entering WAIT, with reqError=0xFFFFFFFF and reqTimeout=1.
REQ-039 Race: fitFinish in the same cycle as the final timeout cycle -> reqTimeout=0, reqError=fitError, fitAbort=0.
REQ-040 Reset mid-WAIT: rst low for 2 cycles, then a stray fitFinish -> no reqFinish, grant=0, busy=0.
REQ-041 Spurious fitFinish in IDLE, and a requester dropping reqStart mid-WAIT -> IDLE unchanged, and reqFinish still pulses once for the dropped request.
